// File: rtl/piso_arb_pkg.sv
// piso_arbiter shared types and constants.
// Optional parity bit: PISO_ARB_PARITY_EN.
package piso_arb_pkg;

  localparam int PISO_ARB_NREQ  = 4;
  localparam int PISO_ARB_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// Search starts at ptr and wraps modulo NREQ.
module rr_arbiter
  import piso_arb_pkg::*;
#(
  parameter int NREQ = PISO_ARB_NREQ,
  parameter int PW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   idx
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] sel;

  // first requester at or after ptr, wrapping
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(NREQ))
        sum = sum - (PW+1)'(NREQ);
      sel = sum[PW-1:0];
      if (!found && req[sel]) begin
        found    = 1'b1;
        win[sel] = 1'b1;
        idx      = sel;
      end
    end
  end

endmodule

// File: rtl/piso_arbiter.sv
// Round-robin shared PISO shifter, MSB first.
// Optional even-parity bit: PISO_ARB_PARITY_EN.
module piso_arbiter
  import piso_arb_pkg::*;
#(
  parameter int NREQ  = PISO_ARB_NREQ,
  parameter int WIDTH = PISO_ARB_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*WIDTH-1:0] data_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              frame_start,
  output logic              busy
);

  localparam int CW = cnt_w(WIDTH);
  localparam int PW = idx_w(NREQ);

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     idx_q, idx_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_valid_q, ser_valid_d;
  logic              fs_q, fs_d;
  logic              busy_q, busy_d;
`ifdef PISO_ARB_PARITY_EN
  logic              par_q, par_d;
`endif

  logic [NREQ-1:0]   win;
  logic [PW-1:0]     win_idx;
  logic [WIDTH-1:0]  word;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req (req),
    .ptr (ptr_q),
    .win (win),
    .idx (win_idx)
  );

  // select the winning requester's word
  always_comb begin
    word = '0;
    for (int i = 0; i < NREQ; i++)
      if (win[i]) word = data_in[i*WIDTH +: WIDTH];
  end

  // next state, datapath and registered-output values
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
`ifdef PISO_ARB_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = SHIFT;
          shreg_d = word;
          gnt_d   = win;
          idx_d   = win_idx;
          cnt_d   = '0;
`ifdef PISO_ARB_PARITY_EN
          par_d   = ^word;
`endif
        end
      end
      SHIFT: begin
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
`ifdef PISO_ARB_PARITY_EN
          state_d = PARITY;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef PISO_ARB_PARITY_EN
      PARITY: state_d = DONE;
`endif
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        if (idx_q == PW'(NREQ-1)) ptr_d = '0;
        else                      ptr_d = idx_q + PW'(1);
      end
      default: state_d = IDLE;
    endcase

    ser_valid_d = 1'b0;
    ser_out_d   = 1'b0;
    fs_d        = 1'b0;
    ack_d       = '0;
    busy_d      = (state_d != IDLE);
    unique case (state_d)
      SHIFT: begin
        ser_valid_d = 1'b1;
        ser_out_d   = shreg_d[WIDTH-1];
        fs_d        = (state_q == IDLE);
      end
`ifdef PISO_ARB_PARITY_EN
      PARITY: begin
        ser_valid_d = 1'b1;
        ser_out_d   = par_q;
      end
`endif
      DONE:    ack_d = gnt_q;
      default: ;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      ack_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      fs_q        <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PISO_ARB_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      fs_q        <= fs_d;
      busy_q      <= busy_d;
`ifdef PISO_ARB_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign gnt         = gnt_q;
  assign ack         = ack_q;
  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_piso_arbiter.sv
// Scoreboard bench for piso_arbiter.
// Honours PISO_ARB_PARITY_EN when defined.
module tb_piso_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
`ifdef PISO_ARB_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int PER = FLEN + 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data_in;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  ser_out;
  logic                  ser_valid;
  logic                  frame_start;
  logic                  busy;

  piso_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data_in     (data_in),
    .gnt         (gnt),
    .ack         (ack),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic            b;
    logic            fs;
    logic [NREQ-1:0] g;
  } ebit_t;

  ebit_t           qb[$];
  logic [NREQ-1:0] qa[$];
  int              fs_log[$];
  int              fs_cyc = 0;
  int              ncmp = 0;
  int              nerr = 0;
  ebit_t           e;
  logic [NREQ-1:0] ea;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // monitor: pop and compare whenever the DUT presents output
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (ser_valid) begin
        if (frame_start) begin
          fs_cyc = cyc;
          fs_log.push_back(cyc);
        end
        if (qb.size() == 0) begin
          chk("unexpected_bit", 32'(ser_valid), 32'd0);
        end else begin
          e = qb.pop_front();
          chk("ser_out", 32'(ser_out), 32'(e.b));
          chk("frame_start", 32'(frame_start), 32'(e.fs));
          chk("gnt", 32'(gnt), 32'(e.g));
          chk("busy", 32'(busy), 32'd1);
        end
      end
      if (ack != '0) begin
        if (qa.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          ea = qa.pop_front();
          chk("ack", 32'(ack), 32'(ea));
          chk("ack_latency", 32'(cyc - fs_cyc), 32'(FLEN));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input int i, input logic [WIDTH-1:0] w,
                           input int n);
    ebit_t x;
    for (int k = 0; k < n; k++) begin
      x.b  = w[WIDTH-1-k];
      x.fs = (k == 0);
      x.g  = NREQ'(1) << i;
      qb.push_back(x);
    end
  endtask

  task automatic push_frame(input int i, input logic [WIDTH-1:0] w);
    ebit_t x;
    push_bits(i, w, WIDTH);
`ifdef PISO_ARB_PARITY_EN
    x.b  = ^w;
    x.fs = 1'b0;
    x.g  = NREQ'(1) << i;
    qb.push_back(x);
`endif
    qa.push_back(NREQ'(1) << i);
  endtask

  task automatic wait_ack(output logic [NREQ-1:0] a);
    a = '0;
    for (int k = 0; k < 40; k++) begin
      if (ack != '0) begin
        a = ack;
        return;
      end
      tick();
    end
    chk("ack_timeout", 32'(a), 32'd1);
  endtask

  task automatic wait_gnt();
    for (int k = 0; k < 40; k++) begin
      if (gnt != '0) return;
      tick();
    end
    chk("gnt_timeout", 32'(gnt), 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 60; k++) begin
      if (qb.size() == 0 && qa.size() == 0) break;
      tick();
    end
    chk("drain", 32'(qb.size() + qa.size()), 32'd0);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_gnt"},  32'(gnt), 32'd0);
    chk({nm, "_ack"},  32'(ack), 32'd0);
    chk({nm, "_sout"}, 32'(ser_out), 32'd0);
    chk({nm, "_sval"}, 32'(ser_valid), 32'd0);
    chk({nm, "_fs"},   32'(frame_start), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  logic [NREQ-1:0] a;

  initial begin
    rst = 1'b0;
    req = '0;
    data_in = '0;
    tick(2);
    chk_idle("reset");
    rst = 1'b1;
    tick();

    // single request, word B3
    data_in[7:0] = 8'hB3;
    push_frame(0, 8'hB3);
    req = 4'b0001;
    wait_ack(a);
    req = '0;
    tick();
    chk("ack_once", 32'(ack), 32'd0);
    drain();

    // all four requesting from ptr 0
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    data_in = {8'hE2, 8'hFF, 8'h55, 8'hAA};
    push_frame(0, 8'hAA);
    push_frame(1, 8'h55);
    push_frame(2, 8'hFF);
    push_frame(3, 8'hE2);
    fs_log.delete();
    req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      wait_ack(a);
      req = req & ~a;
      tick();
    end
    drain();
    chk("frames", 32'(fs_log.size()), 32'd4);
    for (int i = 1; i < 4 && i < fs_log.size(); i++)
      chk("period", 32'(fs_log[i] - fs_log[i-1]), 32'(PER));

    // pointer moves past 2 while 0 and 2 keep requesting
    data_in = {8'h0F, 8'h81, 8'h7E, 8'h3C};
    push_frame(1, 8'h7E);
    req = 4'b0010;
    wait_ack(a);
    req = '0;
    tick();
    drain();
    push_frame(2, 8'h81);
    push_frame(0, 8'h3C);
    push_frame(2, 8'h81);
    req = 4'b0101;
    wait_ack(a);
    tick();
    wait_ack(a);
    req = 4'b0100;
    tick();
    wait_ack(a);
    req = '0;
    tick();
    drain();

    // data change after the grant edge
    push_frame(3, 8'h0F);
    req = 4'b1000;
    wait_gnt();
    data_in[31:24] = 8'hF0;
    wait_ack(a);
    req = '0;
    tick();
    drain();

    // reset in the middle of a frame (at bit 4)
    data_in[23:16] = 8'h5A;
    push_bits(2, 8'h5A, 4);
    req = 4'b0100;
    wait_gnt();
    tick(4);
    rst = 1'b0;
    #1;
    chk_idle("midrst");
    req = '0;
    tick(2);
    chk("abandoned", 32'(qb.size() + qa.size()), 32'd0);
    rst = 1'b1;
    tick();
    data_in[7:0] = 8'hC3;
    push_frame(0, 8'hC3);
    req = 4'b0101;
    wait_ack(a);
    req = '0;
    tick();
    drain();
    tick(3);
    chk("end_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
